mx_block_serializer: RTL and testbench
======================================

// Module: mx_block_serializer
// PURPOSE
//  Output-side companion of the registered MX ALU wrapper: accepts one whole MX block
//  (shared scale + k elements, plus 32-bit scalar result) in parallel and streams it out
//  as narrow beats on a valid/ready link: one scale beat, then element beats.
//  Sits between the ALU result bus and the memory/NoC write port, one clock domain.
// PARAMETERS
//  d      8   element width in bits
//  k      32  elements per MX block
//  w      8   shared-scale width in bits
//  LANES  4   elements per output beat; k % LANES == 0 and w <= LANES*d (elaboration error otherwise)
//  size   w+k*d (localparam) packed block width
// PORTS
//  clk         in   1         clock, all state on rising edge
//  reset       in   1         asynchronous, active-high reset
//  in_valid    in   1         in_vec/in_scalar hold a block
//  in_ready    out  1         block accepted when in_valid & in_ready
//  in_vec      in   size      scale at [size-1 -: w]; element i at [i*d +: d]
//  in_scalar   in   32        scalar result travelling with the block
//  out_valid   out  1         out_* fields carry a beat
//  out_ready   in   1         beat consumed when out_valid & out_ready
//  out_data    out  LANES*d   beat payload
//  out_first   out  1         beat is the scale beat
//  out_last    out  1         beat is the final element beat
//  out_scalar  out  32        captured in_scalar, constant for the whole block
// BEHAVIOUR
//  - Reset (async assert, sync deassert is the integrator's job): state=IDLE, beat count=0,
//    block/scalar registers=0; out_valid=0, out_first=0, out_last=0, out_data=0, out_scalar=0,
//    in_ready=1 once reset is low.
//  - FSM IDLE -> SCALE -> DATA -> (IDLE | SCALE).
//    IDLE: out_valid=0, in_ready=1; accept -> capture in_vec,in_scalar, go SCALE next cycle.
//    SCALE: out_valid=1, out_first=1, out_data={zeros, scale}; on out_ready -> DATA, beat=0.
//    DATA: out_valid=1, out_data = elements [beat*LANES +: LANES], element beat*LANES in low d bits;
//          out_last=1 when beat==k/LANES-1; on out_ready beat++; on last handshake leave DATA.
//  - Beats per block: 1 + k/LANES (9 at defaults). Latency: accept at cycle t -> scale beat valid t+1.
//  - in_ready = IDLE | (DATA & out_last & out_ready): back-to-back blocks with zero bubble;
//    a block accepted on the last beat's handshake goes directly to SCALE, else to IDLE.
//  - in_ready is combinational from state and out_ready; all out_* are register outputs.
//  - Backpressure: while out_valid & !out_ready every out_* field holds stable (AXI-style rule).
//  - in_vec/in_scalar ignored except on the accepting edge; source may change them freely after.
//  - out_scalar updates only on accept; it is valid whenever out_valid=1.
//  - Beat counter width $clog2(k/LANES) (min 1); never exceeds k/LANES-1, no wrap inside a block.
//  - k==LANES: single DATA beat with out_last=1 immediately after the scale beat.
//  - Reset mid-block: block is dropped, no partial tail emitted; next beat after reset is a new
//    block's scale beat.
//  - No data transformation: bits emitted are exactly bits captured.
// TESTING (defaults d=8,k=32,w=8,LANES=4)
//  1 Reset then idle: out_valid=0, in_ready=1, out_scalar=0; hold 10 cycles, no beats.
//  2 Single block, scale=8'h7F, element i=i, scalar=32'hDEADBEEF, out_ready=1 -> 9 beats:
//    beat0 out_data=32'h0000007F first=1; beat1 32'h03020100; beat8 32'h1F1E1D1C last=1;
//    out_scalar=32'hDEADBEEF throughout; in_ready=0 during beats 0-7.
//  3 Back-to-back: two blocks with in_valid held high -> 18 consecutive beats, no bubble,
//    second block's first=1 beat on the cycle after the first block's last handshake.
//  4 Backpressure: out_ready toggled pseudo-randomly (50%) -> payload sequence identical to
//    test 2, every field stable across stalled cycles.
//  5 Reset asserted while beat 4 is stalled -> out_valid drops asynchronously, next block
//    (scale=8'h01) starts with first beat carrying 32'h00000001, no old elements appear.
//  6 LANES=32 build: block streams as 2 beats (scale, all 32 elements with last=1).

Source files
------------

// File: rtl/mx_block_serializer.sv
// Streams one captured MX block (scale + k elements) as a scale beat followed by
// k/LANES element beats on a valid/ready link; out_scalar rides along with the block.
module mx_block_serializer #(
  parameter int d     = 8,
  parameter int k     = 32,
  parameter int w     = 8,
  parameter int LANES = 4,
  localparam int size = w + k*d
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [size-1:0]      in_vec,
  input  logic [31:0]          in_scalar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*d-1:0]   out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic [31:0]          out_scalar
);
  localparam int DW = LANES*d;
  localparam int NB = k/LANES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB-1);

  if ((k % LANES) != 0 || w > LANES*d) begin : g_bad_cfg
    $error("mx_block_serializer: need k %% LANES == 0 and w <= LANES*d");
  end

  typedef enum logic [1:0] {IDLE, SCALE, DATA} state_t;

  state_t                  state_q, state_n;
  logic [BW-1:0]           beat_q, beat_n;
  logic [size-1:0]         blk_q, blk_n;
  logic                    accept;
  logic [LANES-1:0][d-1:0] lane_n;
  logic [DW-1:0]           data_n;

  // out_last is a register, so in_ready only adds one gate on out_ready.
  assign in_ready = (state_q == IDLE) | ((state_q == DATA) & out_last & out_ready);
  assign accept   = in_valid & in_ready;
  assign blk_n    = accept ? in_vec : blk_q;

  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    case (state_q)
      IDLE:  if (in_valid) state_n = SCALE;
      SCALE: if (out_ready) begin
        state_n = DATA;
        beat_n  = '0;
      end
      DATA:  if (out_ready) begin
        if (beat_q == LAST_BEAT) state_n = in_valid ? SCALE : IDLE;
        else                     beat_n  = beat_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from next state so every out_* leaves a flop; a stall
  // keeps state/beat/block unchanged and so re-loads identical values.
  always_comb begin
    lane_n = '0;
    for (int g = 0; g < LANES; g++)
      for (int b = 0; b < NB; b++)
        if (beat_n == BW'(b)) lane_n[g] = blk_n[(b*LANES+g)*d +: d];
  end

  always_comb begin
    data_n = '0;
    if (state_n == SCALE)     data_n = DW'(blk_n[size-1 -: w]);
    else if (state_n == DATA) data_n = lane_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      blk_q      <= '0;
      out_scalar <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      state_q   <= state_n;
      beat_q    <= beat_n;
      blk_q     <= blk_n;
      if (accept) out_scalar <= in_scalar;
      out_valid <= (state_n != IDLE);
      out_first <= (state_n == SCALE);
      out_last  <= (state_n == DATA) && (beat_n == LAST_BEAT);
      out_data  <= data_n;
    end
  end

endmodule

// File: tb/tb_mx_block_serializer.sv
// Directed bench for mx_block_serializer: default build plus a LANES=32 build.
module tb_mx_block_serializer;
  localparam int SIZE = 264;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_valid, out_ready, out_first, out_last;
  logic [SIZE-1:0] in_vec;
  logic [31:0]     in_scalar, out_data, out_scalar;

  logic            in_valid2, in_ready2, out_valid2, out_ready2, out_first2, out_last2;
  logic [SIZE-1:0] in_vec2;
  logic [31:0]     in_scalar2, out_scalar2;
  logic [255:0]    out_data2;

  mx_block_serializer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_scalar(in_scalar), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_first(out_first),
    .out_last(out_last), .out_scalar(out_scalar));

  mx_block_serializer #(.LANES(32)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_vec(in_vec2), .in_scalar(in_scalar2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_first(out_first2),
    .out_last(out_last2), .out_scalar(out_scalar2));

  typedef struct { logic [31:0] data; logic first; logic last; } vec_t;
  typedef struct { logic [31:0] data; logic first; logic last; logic [31:0] scalar; int cyc; } beat_t;

  vec_t  exp_tbl[9];
  beat_t beats[$];
  int    n_tests = 0, n_fail = 0;
  int    cyc_n = 0, acc_cyc = 0, n_acc = 0;
  logic  stalled = 1'b0;
  logic [66:0] sv_fields;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] mk(input logic [7:0] sc, input logic [7:0] base);
    logic [SIZE-1:0] r;
    r = '0;
    r[SIZE-1 -: 8] = sc;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [7:0] sc, input logic [7:0] base, input int j);
    logic [31:0] r;
    r = {24'h0, sc};
    if (j > 0)
      for (int l = 0; l < 4; l++) r[l*8 +: 8] = base + 8'(4*(j-1) + l);
    return r;
  endfunction

  // One cycle: apply inputs, sample just before the edge, then advance past it.
  task automatic drive(input logic iv, input logic [SIZE-1:0] vec, input logic [31:0] sc, input logic ordy);
    in_valid = iv; in_vec = vec; in_scalar = sc; out_ready = ordy;
    #1;
    if (stalled) chk("stall_hold", {out_valid, out_first, out_last, out_data, out_scalar}, sv_fields);
    stalled = out_valid && !out_ready;
    if (stalled) sv_fields = {1'b1, out_first, out_last, out_data, out_scalar};
    if (out_valid && out_ready) beats.push_back('{out_data, out_first, out_last, out_scalar, cyc_n});
    if (in_valid && in_ready) begin acc_cyc = cyc_n; n_acc++; end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic check_q(input string tag, input int off, input logic [7:0] sc,
                         input logic [7:0] base, input logic [31:0] scl);
    if (beats.size() < off + 9) begin
      chk({tag, "_count"}, beats.size(), off + 9);
      return;
    end
    for (int j = 0; j < 9; j++) begin
      chk({tag, "_data"},   beats[off+j].data,   exp_beat(sc, base, j));
      chk({tag, "_first"},  beats[off+j].first,  j == 0);
      chk({tag, "_last"},   beats[off+j].last,   j == 8);
      chk({tag, "_scalar"}, beats[off+j].scalar, scl);
    end
  endtask

  task automatic check_tbl(input string tag);
    if (beats.size() != 9) chk({tag, "_count"}, beats.size(), 9);
    for (int j = 0; j < 9 && j < beats.size(); j++) begin
      chk({tag, "_data"},   beats[j].data,   exp_tbl[j].data);
      chk({tag, "_first"},  beats[j].first,  exp_tbl[j].first);
      chk({tag, "_last"},   beats[j].last,   exp_tbl[j].last);
      chk({tag, "_scalar"}, beats[j].scalar, 32'hDEADBEEF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [SIZE-1:0] junk, v2;
    logic [255:0]    e2;
    int              base_acc;

    exp_tbl[0] = '{32'h0000007F, 1'b1, 1'b0};
    exp_tbl[1] = '{32'h03020100, 1'b0, 1'b0};
    exp_tbl[2] = '{32'h07060504, 1'b0, 1'b0};
    exp_tbl[3] = '{32'h0B0A0908, 1'b0, 1'b0};
    exp_tbl[4] = '{32'h0F0E0D0C, 1'b0, 1'b0};
    exp_tbl[5] = '{32'h13121110, 1'b0, 1'b0};
    exp_tbl[6] = '{32'h17161514, 1'b0, 1'b0};
    exp_tbl[7] = '{32'h1B1A1918, 1'b0, 1'b0};
    exp_tbl[8] = '{32'h1F1E1D1C, 1'b0, 1'b1};

    junk = mk(8'hEE, 8'h40);
    in_valid = 0; in_vec = '0; in_scalar = '0; out_ready = 0;
    in_valid2 = 0; in_vec2 = '0; in_scalar2 = '0; out_ready2 = 0;

    // 1: reset then idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_first",  out_first,  0);
    chk("rst_out_last",   out_last,   0);
    chk("rst_out_data",   out_data,   0);
    chk("rst_out_scalar", out_scalar, 0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    for (int c = 0; c < 10; c++) drive(0, junk, 32'h0, 1);
    chk("idle_no_beats", beats.size(), 0);
    chk("idle_out_scalar", out_scalar, 0);

    // 2: single block, no backpressure
    beats.delete();
    drive(1, mk(8'h7F, 8'h00), 32'hDEADBEEF, 1);
    for (int c = 0; c < 14; c++) begin
      if (out_valid && !out_last) chk("busy_in_ready", in_ready, 0);
      drive(0, junk, 32'h12345678, 1);
    end
    check_tbl("single");
    if (beats.size() > 0) chk("latency", beats[0].cyc - acc_cyc, 1);

    // 3: back-to-back blocks with in_valid held high
    beats.delete();
    base_acc = n_acc;
    for (int c = 0; c < 40; c++) begin
      if (n_acc == base_acc)          drive(1, mk(8'h11, 8'h20), 32'h11111111, 1);
      else if (n_acc == base_acc + 1) drive(1, mk(8'h22, 8'h60), 32'h22222222, 1);
      else                            drive(0, junk, 32'h0, 1);
    end
    chk("b2b_count", beats.size(), 18);
    check_q("b2b_a", 0, 8'h11, 8'h20, 32'h11111111);
    check_q("b2b_b", 9, 8'h22, 8'h60, 32'h22222222);
    if (beats.size() >= 18) begin
      chk("b2b_span", beats[17].cyc - beats[0].cyc, 17);
      chk("b2b_gap",  beats[9].cyc - beats[8].cyc, 1);
    end

    // 4: random backpressure
    beats.delete();
    drive(1, mk(8'h7F, 8'h00), 32'hDEADBEEF, 1);
    for (int c = 0; c < 200 && beats.size() < 9; c++)
      drive(0, junk, 32'h0, 1'($urandom_range(0, 1)));
    drive(0, junk, 32'h0, 1);
    drive(0, junk, 32'h0, 1);
    check_tbl("bp");

    // 5: reset while beat 4 is stalled
    beats.delete();
    drive(1, mk(8'h7F, 8'h00), 32'hDEADBEEF, 1);
    for (int c = 0; c < 20 && beats.size() < 4; c++) drive(0, junk, 32'h0, 1);
    chk("pre_rst_beats", beats.size(), 4);
    repeat (3) drive(0, junk, 32'h0, 0);
    chk("pre_rst_stall_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 0);
    stalled = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    beats.delete();
    drive(1, mk(8'h01, 8'hA0), 32'h00005555, 1);
    for (int c = 0; c < 14; c++) drive(0, junk, 32'h0, 1);
    chk("post_rst_count", beats.size(), 9);
    check_q("post_rst", 0, 8'h01, 8'hA0, 32'h00005555);

    // 6: LANES=32 build -> scale beat then one element beat
    v2 = mk(8'h7F, 8'h00);
    e2 = '0;
    for (int i = 0; i < 32; i++) e2[i*8 +: 8] = 8'(i);
    in_valid2 = 1; in_vec2 = v2; in_scalar2 = 32'hCAFEF00D; out_ready2 = 1;
    #1;
    chk("l32_in_ready", in_ready2, 1);
    @(posedge clk); #1;
    in_valid2 = 0; in_vec2 = junk;
    chk("l32_b0_valid", out_valid2, 1);
    chk("l32_b0_first", out_first2, 1);
    chk("l32_b0_last",  out_last2,  0);
    chk("l32_b0_data",  out_data2,  256'h7F);
    @(posedge clk); #1;
    chk("l32_b1_valid",  out_valid2,  1);
    chk("l32_b1_first",  out_first2,  0);
    chk("l32_b1_last",   out_last2,   1);
    chk("l32_b1_data",   out_data2,   e2);
    chk("l32_b1_scalar", out_scalar2, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("l32_done_valid", out_valid2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
